clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-set controller that sequences loading of the clock unit. Operator buttons walk an FSM through hours, minutes and seconds edit fields and increment a BCD edit buffer. The controller then issues a one-cycle `time_ow` load strobe, which overwrites the running time with the edited value. The block sits between the debounced front-panel buttons and the clock unit's preset inputs and overwrite control.

## Interface
- `REPEAT_DELAY`, default 100: cycles `inc_btn` must be held before the first auto-repeat increment (used only with `AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, default 20: cycles between subsequent auto-repeat increments.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `mode_btn` in 1: debounced, synchronous level. Its rising edge advances the FSM.
- `inc_btn` in 1: debounced, synchronous level. Its rising edge increments the active field.
- `cur_sec_o`, `cur_sec_t`, `cur_min_o`, `cur_min_t`, `cur_hr_o`, `cur_hr_t` in 4 each: live BCD time from the clock unit.
- `set_sec_o`, `set_sec_t`, `set_min_o`, `set_min_t`, `set_hr_o`, `set_hr_t` out 4 each: edit buffer, wired to the clock unit preset inputs.
- `time_ow` out 1: load strobe to the clock unit.
- `editing` out 1: high in any EDIT state.
- `field` out 2: active field, where 0 = none, 1 = hours, 2 = minutes, 3 = seconds.

## Operation
- States: IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, LOAD.
- Edge detect: a registered previous value is kept for each button. An edge is `btn & ~prev`.
- **IDLE.** The buffer copies the `cur_*` inputs every cycle. A mode edge moves the FSM to EDIT_HR, and the buffer holds the `cur_*` values present in the edge cycle.
- **EDIT transitions.** A mode edge moves EDIT_HR → EDIT_MIN → EDIT_SEC → LOAD.
- **LOAD.** Lasts exactly one cycle, with `time_ow` = 1. The FSM then returns to IDLE unconditionally.
- **Increment.**
  - An inc edge in EDIT_x increments only field x of the buffer; other fields hold.
  - An inc edge in IDLE or LOAD is ignored.
- **Increment rule for a field (tens, ones) with max M** (M = 23 for hours, 59 for minutes and seconds):
  - If ones > 9, or the value is ≥ M, the result is 00. This covers invalid captured values.
  - Otherwise, if ones = 9, then ones = 0 and tens = tens + 1.
  - Otherwise ones = ones + 1.
- **Simultaneous edges.** If mode and inc edges occur in the same cycle, mode wins and inc is discarded.
- `field` and `editing` are decoded from the state. In LOAD, `field` = 0 and `editing` = 0.

## Timing
- **Reset** (`rst_n` = 0 at a clock edge):
  - state = IDLE; all `set_*` = 0; `time_ow` = 0; `editing` = 0; `field` = 0.
  - Both button `prev` registers are set to 1, so a button held through reset produces no edge.
- **Reset mid-edit** discards the buffer. No `time_ow` is issued.
- **Edge latency:**
  - If a button rises in cycle N, the new state and buffer are visible in cycle N+1.
  - `time_ow` is high in the single cycle after the mode edge taken in EDIT_SEC.
- `set_*` outputs are registered. They are stable and equal to the edited value throughout the LOAD cycle.
- In the cycle after LOAD, the buffer resumes tracking `cur_*`.
- A held button produces exactly one edge. A new edge requires release for at least one cycle.

## Configuration
- **`AUTO_REPEAT_EN` defined:**
  - A repeat counter starts at the inc edge in an EDIT state.
  - If `inc_btn` stays high, an extra increment fires REPEAT_DELAY cycles after the edge, then every REPEAT_PERIOD cycles.
  - The counter clears on `inc_btn` low, on any state change, or on reset.
  - A mode edge in a repeat-fire cycle wins, and the repeat increment is dropped.
- **`AUTO_REPEAT_EN` undefined:** only inc edges increment. No counter logic is present.

## Test plan
- **Reset with held button:** `rst_n` low for 2 cycles with `inc_btn` held high, then release reset → all outputs 0; state IDLE; no increment occurs.
- **Capture and wrap:** `cur` = 23:31:00; mode edge; 1 inc edge → `set_hr` = 0/0, `field` = 1, `editing` = 1.
- **Minutes rollover and load:** mode to EDIT_MIN from 31; 29 inc edges → `set_min` = 0/0; 2 more mode edges → `time_ow` high for exactly 1 cycle, with `set_*` = 00:00:00 and hours unchanged from the prior edit.
- **Simultaneous edges:** mode and inc edges in the same cycle in EDIT_HR → state EDIT_MIN; hours unchanged.
- **Invalid capture:** `cur_hr` = 2/9 captured; 1 inc edge → hours 0/0.
- **Auto-repeat** (`AUTO_REPEAT_EN`, REPEAT_DELAY = 4, REPEAT_PERIOD = 2): hold `inc_btn` for 10 cycles in EDIT_SEC from 00 → seconds = 04, with increments at edge +0, +4, +6 and +8.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set controller: steps IDLE -> hours -> minutes -> seconds -> one-cycle load, editing a BCD preset buffer.
// Optional feature: define AUTO_REPEAT_EN to let a held inc_btn keep incrementing the active field.
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 100,
  parameter int unsigned REPEAT_PERIOD = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_sec_o,
  input  logic [3:0] cur_sec_t,
  input  logic [3:0] cur_min_o,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_hr_o,
  input  logic [3:0] cur_hr_t,
  output logic [3:0] set_sec_o,
  output logic [3:0] set_sec_t,
  output logic [3:0] set_min_o,
  output logic [3:0] set_min_t,
  output logic [3:0] set_hr_o,
  output logic [3:0] set_hr_t,
  output logic       time_ow,
  output logic       editing,
  output logic [1:0] field
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT_HR  = 3'd1,
    ST_EDIT_MIN = 3'd2,
    ST_EDIT_SEC = 3'd3,
    ST_LOAD     = 3'd4
  } state_t;

  // Out-of-range or non-BCD values (e.g. a captured 29) wrap straight to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                         input logic [7:0] max_val);
    logic [7:0] v;
    v = ({4'd0, tens} * 8'd10) + {4'd0, ones};
    if ((ones > 4'd9) || (v >= max_val)) begin
      bcd_inc = 8'h00;
    end else if (ones == 4'd9) begin
      bcd_inc = {tens + 4'd1, 4'd0};
    end else begin
      bcd_inc = {tens, ones + 4'd1};
    end
  endfunction

  function automatic logic [1:0] field_of(input state_t st);
    case (st)
      ST_EDIT_HR:  field_of = 2'd1;
      ST_EDIT_MIN: field_of = 2'd2;
      ST_EDIT_SEC: field_of = 2'd3;
      default:     field_of = 2'd0;
    endcase
  endfunction

  state_t     r_state;
  state_t     w_next;
  logic       r_mode_prev;
  logic       r_inc_prev;
  logic [7:0] r_hr;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic [7:0] w_hr_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_sec_nxt;
  logic       r_time_ow;
  logic       r_editing;
  logic [1:0] r_field;
  logic       w_mode_edge;
  logic       w_inc_edge;
  logic       w_edit_st;
  logic       w_rep_fire;
  logic       w_do_inc;

  assign w_mode_edge = mode_btn & ~r_mode_prev;
  assign w_inc_edge  = inc_btn & ~r_inc_prev;
  assign w_edit_st   = (r_state == ST_EDIT_HR) | (r_state == ST_EDIT_MIN) | (r_state == ST_EDIT_SEC);
  // A mode edge always wins over any increment source in the same cycle.
  assign w_do_inc    = w_edit_st & ~w_mode_edge & (w_inc_edge | w_rep_fire);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(CNT_MAX + 1);

  logic          r_rep_act;
  logic [CW-1:0] r_rep_cnt;

  assign w_rep_fire = r_rep_act & inc_btn & (r_rep_cnt == {CW{1'b0}});

  // Down-counter to the next repeat; reloads with the period after each fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= {CW{1'b0}};
    end else if (!inc_btn || (w_next != r_state)) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= {CW{1'b0}};
    end else if (w_inc_edge && w_edit_st) begin
      r_rep_act <= 1'b1;
      r_rep_cnt <= CW'(REPEAT_DELAY - 32'd1);
    end else if (w_rep_fire) begin
      r_rep_cnt <= CW'(REPEAT_PERIOD - 32'd1);
    end else if (r_rep_act) begin
      r_rep_cnt <= r_rep_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_rep_cnt <= r_rep_cnt;
    end
  end
`else
  logic w_unused_params;
  assign w_unused_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_rep_fire      = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_mode_edge) w_next = ST_EDIT_HR;  else w_next = ST_IDLE;
      ST_EDIT_HR:  if (w_mode_edge) w_next = ST_EDIT_MIN; else w_next = ST_EDIT_HR;
      ST_EDIT_MIN: if (w_mode_edge) w_next = ST_EDIT_SEC; else w_next = ST_EDIT_MIN;
      ST_EDIT_SEC: if (w_mode_edge) w_next = ST_LOAD;     else w_next = ST_EDIT_SEC;
      ST_LOAD:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Edit buffer: tracks live time in IDLE, increments the active field while editing.
  always_comb begin
    w_hr_nxt  = r_hr;
    w_min_nxt = r_min;
    w_sec_nxt = r_sec;
    if (r_state == ST_IDLE) begin
      w_hr_nxt  = {cur_hr_t, cur_hr_o};
      w_min_nxt = {cur_min_t, cur_min_o};
      w_sec_nxt = {cur_sec_t, cur_sec_o};
    end else if (w_do_inc) begin
      case (r_state)
        ST_EDIT_HR:  w_hr_nxt  = bcd_inc(r_hr[7:4], r_hr[3:0], 8'd23);
        ST_EDIT_MIN: w_min_nxt = bcd_inc(r_min[7:4], r_min[3:0], 8'd59);
        ST_EDIT_SEC: w_sec_nxt = bcd_inc(r_sec[7:4], r_sec[3:0], 8'd59);
        default:     w_hr_nxt  = r_hr;
      endcase
    end else begin
      w_hr_nxt  = r_hr;
      w_min_nxt = r_min;
      w_sec_nxt = r_sec;
    end
  end

  // State, button history, buffer and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
      r_hr        <= 8'h00;
      r_min       <= 8'h00;
      r_sec       <= 8'h00;
      r_time_ow   <= 1'b0;
      r_editing   <= 1'b0;
      r_field     <= 2'd0;
    end else begin
      r_state     <= w_next;
      r_mode_prev <= mode_btn;
      r_inc_prev  <= inc_btn;
      r_hr        <= w_hr_nxt;
      r_min       <= w_min_nxt;
      r_sec       <= w_sec_nxt;
      r_time_ow   <= (w_next == ST_LOAD);
      r_editing   <= (field_of(w_next) != 2'd0);
      r_field     <= field_of(w_next);
    end
  end

  assign set_hr_t  = r_hr[7:4];
  assign set_hr_o  = r_hr[3:0];
  assign set_min_t = r_min[7:4];
  assign set_min_o = r_min[3:0];
  assign set_sec_t = r_sec[7:4];
  assign set_sec_o = r_sec[3:0];
  assign time_ow   = r_time_ow;
  assign editing   = r_editing;
  assign field     = r_field;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios followed by random button/time stimulus,
// every cycle compared against a behavioural model of the set procedure.
module tb_clock_set_ctrl;

  localparam int RD = 4;
  localparam int RP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] cur_sec_o = 4'd0, cur_sec_t = 4'd0, cur_min_o = 4'd0;
  logic [3:0] cur_min_t = 4'd0, cur_hr_o = 4'd0, cur_hr_t = 4'd0;
  logic [3:0] set_sec_o, set_sec_t, set_min_o, set_min_t, set_hr_o, set_hr_t;
  logic       time_ow, editing;
  logic [1:0] field;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1..3 editing hr/min/sec, 4 load. Fields indexed 0=hr,1=min,2=sec.
  int         m_phase = 0;
  logic [3:0] m_t[3];
  logic [3:0] m_o[3];
  logic       m_pm = 1'b1;
  logic       m_pi = 1'b1;
  int         m_rep = -1;

  clock_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_sec_o(cur_sec_o), .cur_sec_t(cur_sec_t), .cur_min_o(cur_min_o),
    .cur_min_t(cur_min_t), .cur_hr_o(cur_hr_o), .cur_hr_t(cur_hr_t),
    .set_sec_o(set_sec_o), .set_sec_t(set_sec_t), .set_min_o(set_min_o),
    .set_min_t(set_min_t), .set_hr_o(set_hr_o), .set_hr_t(set_hr_t),
    .time_ow(time_ow), .editing(editing), .field(field)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval(input logic r, input logic m, input logic i);
    logic me, ie, fire, edit;
    int v, mx, f;
    if (!r) begin
      m_phase = 0; m_pm = 1'b1; m_pi = 1'b1; m_rep = -1;
      for (int k = 0; k < 3; k++) begin m_t[k] = 4'd0; m_o[k] = 4'd0; end
    end else begin
      me = m & ~m_pm;
      ie = i & ~m_pi;
      edit = (m_phase >= 1) && (m_phase <= 3);
      fire = 1'b0;
`ifdef AUTO_REPEAT_EN
      if (m_rep >= RD && i && edit && !me) fire = ((m_rep - RD) % RP) == 0;
`endif
      if (m_phase == 0) begin
        m_t[0] = cur_hr_t;  m_o[0] = cur_hr_o;
        m_t[1] = cur_min_t; m_o[1] = cur_min_o;
        m_t[2] = cur_sec_t; m_o[2] = cur_sec_o;
      end else if (edit && !me && (ie || fire)) begin
        f  = m_phase - 1;
        mx = (f == 0) ? 23 : 59;
        v  = int'(m_t[f]) * 10 + int'(m_o[f]);
        if (m_o[f] > 4'd9 || v >= mx) v = 0; else v = v + 1;
        m_t[f] = 4'(v / 10);
        m_o[f] = 4'(v % 10);
      end
      if (!i || me) m_rep = -1;
      else if (ie && edit) m_rep = 1;
      else if (m_rep >= 0) m_rep = m_rep + 1;
      if (m_phase == 4) m_phase = 0;
      else if (me) m_phase = m_phase + 1;
      m_pm = m; m_pi = i;
    end
  endtask

  task automatic check_outputs();
    logic [1:0] ef;
    ef = (m_phase >= 1 && m_phase <= 3) ? 2'(m_phase) : 2'd0;
    chk("set_hr",  {24'd0, set_hr_t, set_hr_o},   {24'd0, m_t[0], m_o[0]});
    chk("set_min", {24'd0, set_min_t, set_min_o}, {24'd0, m_t[1], m_o[1]});
    chk("set_sec", {24'd0, set_sec_t, set_sec_o}, {24'd0, m_t[2], m_o[2]});
    chk("time_ow", {31'd0, time_ow}, {31'd0, m_phase == 4});
    chk("editing", {31'd0, editing}, {31'd0, ef != 2'd0});
    chk("field",   {30'd0, field},   {30'd0, ef});
  endtask

  task automatic apply(input logic r, input logic m, input logic i);
    rst_n = r; mode_btn = m; inc_btn = i;
    model_eval(r, m, i);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic press_mode();
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_inc();
    apply(1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    cur_hr_t = h[7:4];   cur_hr_o = h[3:0];
    cur_min_t = mi[7:4]; cur_min_o = mi[3:0];
    cur_sec_t = s[7:4];  cur_sec_o = s[3:0];
  endtask

  initial begin
    set_cur(8'h23, 8'h31, 8'h00);
    // Reset held two cycles with inc held: no increment, no edge on release.
    apply(1'b0, 1'b0, 1'b1);
    chk("rst_out", {14'd0, set_hr_t, set_hr_o, set_min_t, set_min_o, time_ow, editing, field},
        32'd0);
    apply(1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b1);
    chk("rst_no_edit", {30'd0, field}, 32'd0);
    apply(1'b1, 1'b0, 1'b0);

    // Capture 23:31:00 and wrap hours.
    press_mode();
    press_inc();
    chk("hr_wrap", {24'd0, set_hr_t, set_hr_o}, 32'h00);
    chk("hr_field", {29'd0, editing, field}, 32'h5);

    // Minutes 31 + 29 increments wraps to 00, then load.
    press_mode();
    for (int k = 0; k < 29; k++) press_inc();
    chk("min_wrap", {24'd0, set_min_t, set_min_o}, 32'h00);
    press_mode();
    apply(1'b1, 1'b1, 1'b0);
    chk("load_ow", {31'd0, time_ow}, 32'd1);
    chk("load_val", {8'd0, set_hr_t, set_hr_o, set_min_t, set_min_o, set_sec_t, set_sec_o}, 32'h0);
    apply(1'b1, 1'b0, 1'b0);
    chk("load_one_cycle", {31'd0, time_ow}, 32'd0);
    apply(1'b1, 1'b0, 1'b0);

    // Simultaneous mode and inc edges: mode wins.
    press_mode();
    apply(1'b1, 1'b1, 1'b1);
    chk("simul_field", {30'd0, field}, 32'd2);
    chk("simul_hr", {24'd0, set_hr_t, set_hr_o}, 32'h23);
    apply(1'b1, 1'b0, 1'b0);
    press_mode();
    press_mode();
    apply(1'b1, 1'b0, 1'b0);

    // Invalid captured hours 29 wrap to 00.
    set_cur(8'h29, 8'h31, 8'h00);
    apply(1'b1, 1'b0, 1'b0);
    press_mode();
    press_inc();
    chk("invalid_hr", {24'd0, set_hr_t, set_hr_o}, 32'h00);
    press_mode();
    press_mode();
`ifdef AUTO_REPEAT_EN
    for (int k = 0; k < 10; k++) apply(1'b1, 1'b0, 1'b1);
    chk("auto_rep", {24'd0, set_sec_t, set_sec_o}, 32'h04);
    apply(1'b1, 1'b0, 1'b0);
`endif
    press_mode();
    apply(1'b1, 1'b0, 1'b0);

    // Random buttons, live time and occasional reset.
    for (int n = 0; n < 800; n++) begin
      set_cur(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      apply(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
